// File: rtl/spart_pkg.sv
// spart shared definitions: register map, frame geometry and the serial FSM state type.
package spart_pkg;

  // ioaddr register select
  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // baud enables per bit time, and data bits per frame
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int OS_W       = $clog2(OVERSAMPLE);
  localparam int BIT_W      = $clog2(DATA_BITS);

  // shared by the transmit and receive state machines
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;

endpackage

// File: rtl/spart_if.sv
// Processor-side control/status bundle between the driver (master) and spart (slave).
// The bidirectional databus stays a plain pin so it remains an ordinary resolved net.
interface spart_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_baud_gen.sv
// Baud-rate enable generator: a down-counter reloaded from the divisor, pulsing en at zero.
module spart_baud_gen #(
  parameter logic [15:0] RESET_DIV = 16'd324
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] div,
  input  logic        reload,
  output logic        en
);
  logic [15:0] cnt_reg;

  // period is div+1 clocks; a divisor write restarts the count with the new value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_reg <= RESET_DIV;
    else if (reload || cnt_reg == 16'd0)
      cnt_reg <= div;
    else
      cnt_reg <= cnt_reg - 16'd1;
  end

  assign en = (cnt_reg == 16'd0);
endmodule

// File: rtl/spart.sv
// spart: bus-programmed UART with a 16x oversampled transmitter and receiver.
module spart
  import spart_pkg::*;
#(
  parameter logic [15:0] RESET_DIV = 16'd324
) (
  input  logic       clk,
  input  logic       rst,
  spart_if.slave     bus,
  inout  wire  [7:0] databus,
  output logic       txd,
  input  logic       rxd
);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  // ---------------- bus decode ----------------
  logic       bus_wr, bus_rd;
  logic [7:0] wdata;
  logic [7:0] rdata;
  assign bus_wr = bus.iocs & ~bus.iorw;
  assign bus_rd = bus.iocs &  bus.iorw;
  assign wdata  = databus;

  // ---------------- divisor + baud generator ----------------
  logic [15:0] div_reg, div_next;
  logic        div_load;
  logic        en;

  // the new divisor is forwarded to the baud counter in the same cycle it is written
  always_comb begin
    div_next = div_reg;
    div_load = 1'b0;
    if (bus_wr && bus.ioaddr == ADDR_DBL) begin
      div_next = {div_reg[15:8], wdata};
      div_load = 1'b1;
    end else if (bus_wr && bus.ioaddr == ADDR_DBH) begin
      div_next = {wdata, div_reg[7:0]};
      div_load = 1'b1;
    end
  end

  // divisor register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) div_reg <= RESET_DIV;
    else      div_reg <= div_next;
  end

  spart_baud_gen #(.RESET_DIV(RESET_DIV)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .div    (div_next),
    .reload (div_load),
    .en     (en)
  );

  // ---------------- transmitter ----------------
  ser_state_t           tx_state_reg, tx_state_next;
  logic [OS_W-1:0]      tx_cnt_reg, tx_cnt_next;
  logic [BIT_W-1:0]     tx_bit_reg, tx_bit_next;
  logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
  logic                 tbr_int;

  // TX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_reg <= IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
    end
  end

  // TX next state and line outputs; each state spans OVERSAMPLE baud enables
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    txd           = 1'b1;
    tbr_int       = 1'b0;
    case (tx_state_reg)
      IDLE: begin
        tbr_int = 1'b1;
        if (bus_wr && bus.ioaddr == ADDR_BUF) begin
          tx_shift_next = wdata;
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_state_next = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (en) begin
          if (tx_cnt_reg == OS_LAST) begin
            tx_cnt_next   = '0;
            tx_state_next = DATA;
          end else begin
            tx_cnt_next = tx_cnt_reg + OS_ONE;
          end
        end
      end
      DATA: begin
        txd = tx_shift_reg[tx_bit_reg];
        if (en) begin
          if (tx_cnt_reg == OS_LAST) begin
            tx_cnt_next = '0;
            if (tx_bit_reg == BIT_LAST) tx_state_next = STOP;
            else                        tx_bit_next   = tx_bit_reg + BIT_ONE;
          end else begin
            tx_cnt_next = tx_cnt_reg + OS_ONE;
          end
        end
      end
      STOP: begin
        txd = 1'b1;
        if (en) begin
          if (tx_cnt_reg == OS_LAST) begin
            tx_cnt_next   = '0;
            tx_state_next = IDLE;
          end else begin
            tx_cnt_next = tx_cnt_reg + OS_ONE;
          end
        end
      end
      default: tx_state_next = IDLE;
    endcase
  end

  assign bus.tbr = tbr_int;

  // ---------------- receiver ----------------
  logic                 rxd_s1, rxd_s2, rxd_s3;
  logic                 rx_fall;
  ser_state_t           rx_state_reg, rx_state_next;
  logic [OS_W-1:0]      rx_cnt_reg, rx_cnt_next;
  logic [BIT_W-1:0]     rx_bit_reg, rx_bit_next;
  logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic                 rx_done;
  logic [7:0]           rx_buf_reg;
  logic                 rda_reg;

  // two-flop synchroniser plus a history flop for falling-edge detection; idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_s3 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
    end
  end

  assign rx_fall = rxd_s3 & ~rxd_s2;

  // RX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_reg <= IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
    end
  end

  // RX next state: start bit checked mid-bit, later bits every OVERSAMPLE enables after
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_done       = 1'b0;
    case (rx_state_reg)
      IDLE: begin
        if (rx_fall) begin
          rx_cnt_next   = '0;
          rx_state_next = START;
        end
      end
      START: begin
        if (en) begin
          if (rx_cnt_reg == OS_MID) begin
            rx_cnt_next   = '0;
            rx_bit_next   = '0;
            // a start bit that reads high again was only a glitch
            rx_state_next = rxd_s2 ? IDLE : DATA;
          end else begin
            rx_cnt_next = rx_cnt_reg + OS_ONE;
          end
        end
      end
      DATA: begin
        if (en) begin
          if (rx_cnt_reg == OS_LAST) begin
            rx_cnt_next   = '0;
            rx_shift_next = {rxd_s2, rx_shift_reg[DATA_BITS-1:1]};
            if (rx_bit_reg == BIT_LAST) rx_state_next = STOP;
            else                        rx_bit_next   = rx_bit_reg + BIT_ONE;
          end else begin
            rx_cnt_next = rx_cnt_reg + OS_ONE;
          end
        end
      end
      STOP: begin
        if (en) begin
          if (rx_cnt_reg == OS_LAST) begin
            rx_cnt_next   = '0;
            rx_done       = rxd_s2;
            rx_state_next = IDLE;
          end else begin
            rx_cnt_next = rx_cnt_reg + OS_ONE;
          end
        end
      end
      default: rx_state_next = IDLE;
    endcase
  end

  // receive buffer and rda; a completing frame wins over a simultaneous buffer read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_buf_reg <= 8'h00;
      rda_reg    <= 1'b0;
    end else if (rx_done) begin
      rx_buf_reg <= rx_shift_reg;
      rda_reg    <= 1'b1;
    end else if (bus_rd && bus.ioaddr == ADDR_BUF) begin
      rda_reg <= 1'b0;
    end
  end

  assign bus.rda = rda_reg;

  // ---------------- read path ----------------
  // zero-wait-state read mux
  always_comb begin
    rdata = 8'h00;
    case (bus.ioaddr)
      ADDR_BUF:  rdata = rx_buf_reg;
      ADDR_STAT: rdata = {6'b0, tbr_int, rda_reg};
      ADDR_DBL:  rdata = div_reg[7:0];
      ADDR_DBH:  rdata = div_reg[15:8];
      default:   rdata = 8'h00;
    endcase
  end

  assign databus = bus_rd ? rdata : 8'hzz;

endmodule

// File: tb/tb_spart.sv
// Self-checking bench for spart: randomized bytes checked against a frame-level model.
module tb_spart;
  import spart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spart_if intf();
  wire  [7:0] databus;
  logic       tb_drv  = 1'b0;
  logic [7:0] tb_data = 8'h00;
  logic       txd;
  logic       rxd = 1'b1;

  assign databus = tb_drv ? tb_data : 8'hzz;

  spart #(.RESET_DIV(16'd324)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (intf),
    .databus (databus),
    .txd     (txd),
    .rxd     (rxd)
  );

  int checks = 0;
  int passed = 0;

  // behavioural receive model
  logic [7:0] exp_buf = 8'h00;
  logic       exp_rda = 1'b0;

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    intf.iocs = 1'b1; intf.iorw = 1'b0; intf.ioaddr = a;
    tb_drv = 1'b1; tb_data = d;
    @(posedge clk); #1;
    intf.iocs = 1'b0; tb_drv = 1'b0;
    $display("write addr=%0d data=%h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    intf.iocs = 1'b1; intf.iorw = 1'b1; intf.ioaddr = a; tb_drv = 1'b0;
    #1 d = databus;
    @(posedge clk); #1;
    intf.iocs = 1'b0; intf.iorw = 1'b0;
    $display("read  addr=%0d data=%h", a, d);
  endtask

  task automatic set_div(input logic [15:0] v);
    bus_write(ADDR_DBL, v[7:0]);
    bus_write(ADDR_DBH, v[15:8]);
  endtask

  // sends one frame on rxd, idle-high lead-in first; reports the cycle rda rose (-1 if not)
  task automatic rx_send(input logic [7:0] data, input logic stop, output int rise);
    logic [9:0] frame;
    logic       prev;
    frame = {stop, data, 1'b0};
    rise  = -1;
    repeat (4) begin @(negedge clk); rxd = 1'b1; end
    prev = intf.rda;
    for (int t = 0; t < 160; t++) begin
      @(negedge clk);
      if (intf.rda && !prev && rise < 0) rise = t;
      prev = intf.rda;
      rxd  = frame[t/16];
    end
    @(negedge clk); rxd = 1'b1;
    if (stop) begin exp_buf = data; exp_rda = 1'b1; end
    $display("rx frame data=%h stop=%0d rise=%0d", data, stop, rise);
  endtask

  task automatic test_reset;
    logic [7:0] d;
    rst = 1'b0;
    intf.iocs = 1'b0; intf.iorw = 1'b0; intf.ioaddr = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd); else passed++;
    checks++; if (intf.tbr !== 1'b1) $display("FAIL reset_tbr: got %b expected 1", intf.tbr); else passed++;
    checks++; if (intf.rda !== 1'b0) $display("FAIL reset_rda: got %b expected 0", intf.rda); else passed++;
    @(negedge clk); rst = 1'b1;
    bus_read(ADDR_STAT, d);
    checks++; if (d !== 8'h02) $display("FAIL reset_status: got %h expected 02", d); else passed++;
    bus_read(ADDR_DBL, d);
    checks++; if (d !== 8'h44) $display("FAIL reset_dbl: got %h expected 44", d); else passed++;
    bus_read(ADDR_DBH, d);
    checks++; if (d !== 8'h01) $display("FAIL reset_dbh: got %h expected 01", d); else passed++;
    bus_read(ADDR_BUF, d);
    checks++; if (d !== 8'h00) $display("FAIL reset_rxbuf: got %h expected 00", d); else passed++;
  endtask

  task automatic test_divisor;
    logic [15:0] v;
    logic [7:0]  d;
    v = 16'($urandom);
    set_div(v);
    bus_read(ADDR_DBL, d);
    checks++; if (d !== v[7:0]) $display("FAIL div_low: got %h expected %h", d, v[7:0]); else passed++;
    bus_read(ADDR_DBH, d);
    checks++; if (d !== v[15:8]) $display("FAIL div_high: got %h expected %h", d, v[15:8]); else passed++;
    bus_write(ADDR_STAT, 8'hFF);
    bus_read(ADDR_STAT, d);
    checks++; if (d !== {6'b0, 1'b1, exp_rda}) $display("FAIL stat_write_ignored: got %h expected %h", d, {6'b0, 1'b1, exp_rda}); else passed++;
    set_div(16'h0000);
  endtask

  // one frame at DB=0: txd sampled every clock against the 10-bit frame, 16 clocks per bit
  task automatic run_tx(input logic [7:0] data, input bit inject);
    logic [9:0] frame;
    logic       samp [0:199];
    int         low;
    int         bad;
    frame = {1'b1, data, 1'b0};
    bus_write(ADDR_BUF, data);
    low = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (intf.tbr) begin low = k; break; end
      if (k < 200) samp[k] = txd;
      if (inject && k == 40) begin
        intf.iocs = 1'b1; intf.iorw = 1'b0; intf.ioaddr = ADDR_BUF;
        tb_drv = 1'b1; tb_data = 8'h3C;
      end
      if (inject && k == 41) begin intf.iocs = 1'b0; tb_drv = 1'b0; end
    end
    intf.iocs = 1'b0; tb_drv = 1'b0;
    $display("tx frame data=%h inject=%0d tbr_low=%0d", data, inject, low);
    checks++; if (low !== 160) $display("FAIL tx_tbr_low: got %0d expected 160", low); else passed++;
    for (int j = 0; j < 10; j++) begin
      bad = 0;
      for (int c = 0; c < 16; c++) if (samp[j*16+c] !== frame[j]) bad++;
      checks++;
      if (bad != 0) $display("FAIL tx_bit%0d: %0d of 16 clocks differ from expected %b", j, bad, frame[j]);
      else passed++;
    end
    checks++; if (txd !== 1'b1) $display("FAIL tx_idle_after: got %b expected 1", txd); else passed++;
  endtask

  task automatic test_tx;
    run_tx(8'hA5, 1'b1);
    run_tx(8'($urandom), 1'b0);
    run_tx(8'($urandom), 1'b0);
  endtask

  // slower divisor: duration within one enable period, bits sampled mid-bit
  task automatic test_tx_slow;
    logic [15:0] db;
    logic [9:0]  frame;
    logic [7:0]  data;
    logic        samp [0:1023];
    int          len, low, lo_lim, hi_lim;
    db    = 16'($urandom_range(1, 3));
    data  = 8'($urandom);
    frame = {1'b1, data, 1'b0};
    len   = 16 * (int'(db) + 1);
    set_div(db);
    bus_write(ADDR_BUF, data);
    low = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (intf.tbr) begin low = k; break; end
      if (k < 1024) samp[k] = txd;
    end
    lo_lim = 10 * len - (int'(db) + 1);
    hi_lim = 10 * len + (int'(db) + 1);
    $display("tx slow db=%0d data=%h tbr_low=%0d", db, data, low);
    checks++;
    if (low < lo_lim || low > hi_lim) $display("FAIL tx_slow_len: got %0d expected %0d..%0d", low, lo_lim, hi_lim);
    else passed++;
    for (int j = 0; j < 10; j++) begin
      checks++;
      if (samp[j*len + len/2] !== frame[j])
        $display("FAIL tx_slow_bit%0d: got %b expected %b", j, samp[j*len + len/2], frame[j]);
      else passed++;
    end
    set_div(16'h0000);
  endtask

  // divisor rewritten mid-frame: the transmitter must still return to idle
  task automatic test_div_midframe;
    int done;
    set_div(16'd3);
    bus_write(ADDR_BUF, 8'($urandom));
    repeat (100) @(negedge clk);
    bus_write(ADDR_DBL, 8'h00);
    done = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (intf.tbr) begin done = k; break; end
    end
    $display("div change mid-frame: tbr back after %0d clocks", done);
    checks++; if (done < 0) $display("FAIL div_midframe_hang: got tbr=%b expected 1", intf.tbr); else passed++;
    run_tx(8'($urandom), 1'b0);
  endtask

  task automatic test_rx_basic;
    logic [7:0] d;
    int         rise;
    rx_send(8'h5A, 1'b1, rise);
    checks++; if (rise < 144 || rise > 159) $display("FAIL rx_rda_timing: got %0d expected 144..159", rise); else passed++;
    checks++; if (intf.rda !== 1'b1) $display("FAIL rx_rda_set: got %b expected 1", intf.rda); else passed++;
    bus_read(ADDR_STAT, d);
    checks++; if (d !== 8'h03) $display("FAIL rx_status: got %h expected 03", d); else passed++;
    bus_read(ADDR_BUF, d);
    exp_rda = 1'b0;
    checks++; if (d !== 8'h5A) $display("FAIL rx_data: got %h expected 5a", d); else passed++;
    checks++; if (intf.rda !== 1'b0) $display("FAIL rx_rda_clear: got %b expected 0", intf.rda); else passed++;
  endtask

  task automatic test_rx_overrun;
    logic [7:0] d;
    int         rise;
    rx_send(8'h11, 1'b1, rise);
    rx_send(8'h22, 1'b1, rise);
    checks++; if (intf.rda !== 1'b1) $display("FAIL overrun_rda: got %b expected 1", intf.rda); else passed++;
    bus_read(ADDR_BUF, d);
    exp_rda = 1'b0;
    checks++; if (d !== 8'h22) $display("FAIL overrun_data: got %h expected 22", d); else passed++;
  endtask

  task automatic test_rx_errors;
    logic [7:0] d;
    int         rise;
    rx_send(8'($urandom), 1'b0, rise);
    checks++; if (intf.rda !== exp_rda) $display("FAIL framing_rda: got %b expected %b", intf.rda, exp_rda); else passed++;
    // short low glitch
    for (int t = 0; t < 4; t++) begin @(negedge clk); rxd = 1'b0; end
    @(negedge clk); rxd = 1'b1;
    repeat (200) @(negedge clk);
    $display("rx glitch 4 clocks");
    checks++; if (intf.rda !== exp_rda) $display("FAIL glitch_rda: got %b expected %b", intf.rda, exp_rda); else passed++;
    // line stuck low: one framing error, then silence until a fresh edge
    for (int t = 0; t < 500; t++) begin @(negedge clk); rxd = 1'b0; end
    @(negedge clk); rxd = 1'b1;
    $display("rx held low 500 clocks");
    checks++; if (intf.rda !== exp_rda) $display("FAIL stuck_low_rda: got %b expected %b", intf.rda, exp_rda); else passed++;
    bus_read(ADDR_BUF, d);
    checks++; if (d !== exp_buf) $display("FAIL stuck_low_buf: got %h expected %h", d, exp_buf); else passed++;
    rx_send(8'($urandom), 1'b1, rise);
    bus_read(ADDR_BUF, d);
    exp_rda = 1'b0;
    checks++; if (d !== exp_buf) $display("FAIL after_stuck_data: got %h expected %h", d, exp_buf); else passed++;
  endtask

  task automatic test_rx_random;
    logic [7:0] d, data;
    logic       stop;
    int         rise;
    for (int i = 0; i < 6; i++) begin
      data = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      rx_send(data, stop, rise);
      checks++; if (intf.rda !== exp_rda) $display("FAIL rand_rda%0d: got %b expected %b", i, intf.rda, exp_rda); else passed++;
      bus_read(ADDR_STAT, d);
      checks++; if (d !== {6'b0, 1'b1, exp_rda}) $display("FAIL rand_stat%0d: got %h expected %h", i, d, {6'b0, 1'b1, exp_rda}); else passed++;
      if ($urandom_range(0, 1) == 1) begin
        bus_read(ADDR_BUF, d);
        exp_rda = 1'b0;
        checks++; if (d !== exp_buf) $display("FAIL rand_data%0d: got %h expected %h", i, d, exp_buf); else passed++;
      end
    end
  endtask

  // asynchronous reset in the middle of a TX frame with an unread RX byte pending
  task automatic test_reset_midframe;
    logic [7:0] d;
    int         rise;
    rx_send(8'($urandom), 1'b1, rise);
    bus_write(ADDR_BUF, 8'h00);
    repeat (20) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    $display("async reset mid-frame");
    checks++; if (intf.tbr !== 1'b1) $display("FAIL midreset_tbr: got %b expected 1", intf.tbr); else passed++;
    checks++; if (txd !== 1'b1) $display("FAIL midreset_txd: got %b expected 1", txd); else passed++;
    checks++; if (intf.rda !== 1'b0) $display("FAIL midreset_rda: got %b expected 0", intf.rda); else passed++;
    @(negedge clk); rst = 1'b1;
    exp_buf = 8'h00; exp_rda = 1'b0;
    bus_read(ADDR_DBL, d);
    checks++; if (d !== 8'h44) $display("FAIL midreset_dbl: got %h expected 44", d); else passed++;
    bus_read(ADDR_BUF, d);
    checks++; if (d !== exp_buf) $display("FAIL midreset_buf: got %h expected %h", d, exp_buf); else passed++;
    set_div(16'h0000);
    run_tx(8'($urandom), 1'b0);
  endtask

  initial begin
    test_reset();
    test_divisor();
    test_tx();
    test_tx_slow();
    test_div_midframe();
    test_rx_basic();
    test_rx_overrun();
    test_rx_errors();
    test_rx_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
